// File: rtl/fifo_burst_reader_if.sv
// FIFO first-word-fall-through read port and valid/ready output stream of fifo_burst_reader.
// master = the burst reader, slave = the FIFO/stream environment around it.
interface fifo_burst_reader_if #(
    parameter int DATAWIDTH = 18
);
    logic [DATAWIDTH-1:0] fifo_rd_data;
    logic                 fifo_ne;
    logic                 fifo_re;
    logic                 flush;
    logic [DATAWIDTH-1:0] out_data;
    logic                 out_sof;
    logic                 out_eof;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        input  fifo_rd_data, fifo_ne, flush, out_ready,
        output fifo_re, out_data, out_sof, out_eof, out_valid
    );

    modport slave (
        output fifo_rd_data, fifo_ne, flush, out_ready,
        input  fifo_re, out_data, out_sof, out_eof, out_valid
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a FWFT FIFO through a 1-word hold register and 2-entry skid into an sof/eof framed stream.
// Optional statistics outputs are enabled by defining FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader #(
    parameter int DATAWIDTH = 18,
    parameter int BURSTBITS = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                reset_l,
`ifdef FIFO_BURST_READER_STATS_EN
    output logic [31:0]         stat_words,
    output logic [15:0]         stat_bursts,
    output logic                stat_tmo,
`endif
    fifo_burst_reader_if.master bus
);
    localparam int              IDXW      = BURSTBITS + 1;
    localparam logic [IDXW-1:0] BURST_LEN = IDXW'(1 << BURSTBITS);
    localparam logic [15:0]     TMO       = 16'(TIMEOUT);

    typedef enum logic {IDLE, HOLD} state_t;

    typedef struct packed {
        logic [DATAWIDTH-1:0] data;
        logic                 sof;
        logic                 eof;
    } entry_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] hold_data_q, hold_data_d;
    logic [IDXW-1:0]      hold_idx_q, hold_idx_d;
    logic [15:0]          timer_q, timer_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [1:0]           skid_occ_q;
    entry_t               sk0_q, sk1_q;

    logic   pop, rel, rel_eof, full, flush_any, tmo_hit, out_fire;
    entry_t rel_entry;

    assign full      = (skid_occ_q == 2'd2);
    assign flush_any = bus.flush || flush_pend_q;
    assign tmo_hit   = (timer_q == TMO);
    // Gated by reset so the FIFO is never popped while our state is being discarded.
    assign pop       = reset_l && bus.fifo_ne && ((state_q == IDLE) || !full);
    assign out_fire  = (skid_occ_q != 2'd0) && bus.out_ready;

    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_idx_d   = hold_idx_q;
        timer_d      = timer_q;
        flush_pend_d = flush_pend_q;
        rel          = 1'b0;
        rel_eof      = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d      = '0;
                flush_pend_d = 1'b0;
                if (pop) begin
                    state_d     = HOLD;
                    hold_data_d = bus.fifo_rd_data;
                    hold_idx_d  = IDXW'(1);
                end
            end
            HOLD: begin
                // A pop always releases the held word; it beats a same-cycle timeout.
                if (!full) begin
                    if (pop) begin
                        rel     = 1'b1;
                        rel_eof = (hold_idx_q == BURST_LEN);
                    end else if ((hold_idx_q == BURST_LEN) || flush_any || tmo_hit) begin
                        rel     = 1'b1;
                        rel_eof = 1'b1;
                    end
                end else if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                if (rel) flush_pend_d = 1'b0;
                if (pop) begin
                    hold_data_d = bus.fifo_rd_data;
                    hold_idx_d  = rel_eof ? IDXW'(1) : hold_idx_q + IDXW'(1);
                    timer_d     = '0;
                end else if (rel) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (!bus.fifo_ne && !tmo_hit) begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        rel_entry.data = hold_data_q;
        rel_entry.sof  = (hold_idx_q == IDXW'(1));
        rel_entry.eof  = rel_eof;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q      <= IDLE;
            hold_data_q  <= '0;
            hold_idx_q   <= '0;
            timer_q      <= '0;
            flush_pend_q <= 1'b0;
            skid_occ_q   <= 2'd0;
            sk0_q        <= '0;
            sk1_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_idx_q   <= hold_idx_d;
            timer_q      <= timer_d;
            flush_pend_q <= flush_pend_d;
            // Push with pop is only possible at occupancy 1, so the new word becomes the head.
            case ({rel, out_fire})
                2'b10: begin
                    if (skid_occ_q == 2'd0) sk0_q <= rel_entry;
                    else                    sk1_q <= rel_entry;
                    skid_occ_q <= skid_occ_q + 2'd1;
                end
                2'b01: begin
                    sk0_q      <= sk1_q;
                    skid_occ_q <= skid_occ_q - 2'd1;
                end
                2'b11:   sk0_q <= rel_entry;
                default: ;
            endcase
        end
    end

    assign bus.fifo_re   = pop;
    assign bus.out_valid = (skid_occ_q != 2'd0);
    assign bus.out_data  = sk0_q.data;
    assign bus.out_sof   = sk0_q.sof;
    assign bus.out_eof   = sk0_q.eof;

`ifdef FIFO_BURST_READER_STATS_EN
    logic [31:0] stat_words_q;
    logic [15:0] stat_bursts_q;
    logic        stat_tmo_q;
    logic        tmo_close;

    assign tmo_close = rel && !pop && (hold_idx_q != BURST_LEN) && !flush_any;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            stat_words_q  <= '0;
            stat_bursts_q <= '0;
            stat_tmo_q    <= 1'b0;
        end else begin
            if (out_fire)              stat_words_q  <= stat_words_q + 32'd1;
            if (out_fire && sk0_q.eof) stat_bursts_q <= stat_bursts_q + 16'd1;
            if (tmo_close)             stat_tmo_q    <= 1'b1;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_bursts = stat_bursts_q;
    assign stat_tmo    = stat_tmo_q;
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO model, scoreboard of framed words, vector table.
module tb_fifo_burst_reader;
    localparam int DW  = 18;
    localparam int BB  = 4;
    localparam int TMO = 64;
    localparam int BL  = 1 << BB;

    typedef struct { logic [DW-1:0] data; logic sof; logic eof; } exp_t;
    typedef struct { int nwords; bit flush; int exp_eofs; int exp_lat; } vec_t;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATAWIDTH(DW)) bus ();

`ifdef FIFO_BURST_READER_STATS_EN
    logic [31:0] stat_words;
    logic [15:0] stat_bursts;
    logic        stat_tmo;
`endif

    fifo_burst_reader #(.DATAWIDTH(DW), .BURSTBITS(BB), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
`ifdef FIFO_BURST_READER_STATS_EN
        .stat_words (stat_words),
        .stat_bursts(stat_bursts),
        .stat_tmo   (stat_tmo),
`endif
        .bus        (bus)
    );

    logic [DW-1:0] fq[$];
    exp_t          exp_q[$];
    vec_t          tbl[5];
    int n_vec = 0, n_err = 0, cyc = 0, pop_cnt = 0, eof_cnt = 0;
    int last_pop_cyc = 0, last_xfer_cyc = 0, underflow = 0, next_id = 0;

    task automatic check(string name, int got, int req);
        n_vec++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic push_word(logic sof, logic eof);
        logic [DW-1:0] d;
        d = DW'(next_id * 37 + 5);
        next_id++;
        fq.push_back(d);
        exp_q.push_back('{d, sof, eof});
    endtask

    // One clock: present FIFO head, sample just after the falling edge, let the rising edge act.
    task automatic step();
        logic popped;
        exp_t e;
        bus.fifo_ne      = (fq.size() != 0);
        bus.fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
        #1;
        if (bus.fifo_re && !bus.fifo_ne) underflow++;
        popped = bus.fifo_re;
        if (popped) begin
            pop_cnt++;
            last_pop_cyc = cyc;
        end
        if (bus.out_valid && bus.out_ready) begin
            last_xfer_cyc = cyc;
            if (bus.out_eof) eof_cnt++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL extra_word: got data=%h sof=%b eof=%b, required no word",
                         bus.out_data, bus.out_sof, bus.out_eof);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_data, bus.out_sof, bus.out_eof} !== {e.data, e.sof, e.eof}) begin
                    n_err++;
                    $display("FAIL word: got data=%h sof=%b eof=%b required data=%h sof=%b eof=%b",
                             bus.out_data, bus.out_sof, bus.out_eof, e.data, e.sof, e.eof);
                end
            end
        end
        @(posedge clk);
        if (popped) void'(fq.pop_front());
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(string name, int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] ref_d;
        logic          ref_s, ref_e, have_ref, stable;
        int            p0, e0, n;

        bus.fifo_ne      = 1'b0;
        bus.fifo_rd_data = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
        @(negedge clk);
        step();
        step();
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_sof", int'(bus.out_sof), 0);
        check("rst_eof", int'(bus.out_eof), 0);
        check("rst_data", int'(bus.out_data), 0);
        reset_l = 1'b1;
        step();

        tbl[0] = '{40, 1'b0, 3, TMO + 2};
        tbl[1] = '{16, 1'b0, 1, 2};
        tbl[2] = '{5,  1'b1, 1, 2};
        tbl[3] = '{1,  1'b0, 1, TMO + 2};
        tbl[4] = '{17, 1'b0, 2, TMO + 2};
        bus.out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            e0 = eof_cnt;
            for (int k = 1; k <= tbl[v].nwords; k++)
                push_word((k - 1) % BL == 0, (k % BL == 0) || (k == tbl[v].nwords));
            if (tbl[v].flush) begin
                for (int i = 0; i < 200 && fq.size() != 0; i++) step();
                bus.flush = 1'b1;
                step();
                bus.flush = 1'b0;
                drain("flush_drain", 2);
            end else begin
                drain("tbl_drain", TMO + 100);
            end
            check("eof_count", eof_cnt - e0, tbl[v].exp_eofs);
            check("last_latency", last_xfer_cyc - last_pop_cyc, tbl[v].exp_lat);
`ifdef FIFO_BURST_READER_STATS_EN
            if (v == 0) begin
                check("stat_words", int'(stat_words), 40);
                check("stat_bursts", int'(stat_bursts), 3);
                check("stat_tmo", int'(stat_tmo), 1);
            end
`endif
        end

        // Back-pressure: only hold + two skid entries may be taken from the FIFO.
        bus.out_ready = 1'b0;
        p0 = pop_cnt;
        for (int k = 1; k <= 10; k++) push_word(k == 1, k == 10);
        have_ref = 1'b0;
        stable   = 1'b1;
        ref_d = '0; ref_s = 1'b0; ref_e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.out_valid) begin
                if (!have_ref) begin
                    ref_d = bus.out_data; ref_s = bus.out_sof; ref_e = bus.out_eof;
                    have_ref = 1'b1;
                end else if ({bus.out_data, bus.out_sof, bus.out_eof} !== {ref_d, ref_s, ref_e}) begin
                    stable = 1'b0;
                end
            end
        end
        check("stall_pops", pop_cnt - p0, 3);
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_stable", int'(stable), 1);
        check("stall_head", int'({bus.out_sof, bus.out_data}), int'({1'b1, exp_q[0].data}));
        bus.out_ready = 1'b1;
        drain("stall_drain", TMO + 100);

        // Refill on exactly the cycle the timer saturates: burst continues across idx 16.
        for (int k = 1; k <= 14; k++) push_word(k == 1, 1'b0);
        for (int i = 0; i < 200 && fq.size() != 0; i++) step();
        for (int i = 0; i < TMO; i++) step();
        for (int k = 15; k <= 18; k++) push_word(k == 17, k == 16 || k == 18);
        drain("refill_drain", TMO + 100);

        // Reset mid-burst with the skid full.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            fq.push_back(DW'(next_id * 37 + 5));
            next_id++;
        end
        for (int i = 0; i < 6; i++) step();
        check("pre_rst_valid", int'(bus.out_valid), 1);
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_sof", int'(bus.out_sof), 0);
        check("mid_rst_eof", int'(bus.out_eof), 0);
        check("mid_rst_data", int'(bus.out_data), 0);
        check("mid_rst_fifo_left", fq.size(), 3);
        n = fq.size();
        for (int i = 0; i < n; i++) exp_q.push_back('{fq[i], i == 0, i == n - 1});
        bus.out_ready = 1'b1;
        drain("post_rst_drain", TMO + 100);

        check("underflow", underflow, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
